// File: rtl/led_pattern_pkg.sv
// Shared mode encoding for the LED pattern controller.
package led_pattern_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'd0;
    localparam mode_t MODE_BLINK = 2'd1;
    localparam mode_t MODE_RUN   = 2'd2;
    localparam mode_t MODE_ALT   = 2'd3;

endpackage : led_pattern_pkg

// File: rtl/led_pattern_ctrl_key_debounce.sv
// One key bit: 2-flop synchroniser followed by a stable-level debounce counter.
module key_debounce #(
    parameter int unsigned DEB_CYC = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_db
);

    localparam int unsigned DEB_W = $clog2(DEB_CYC);

    logic             key_meta;
    logic             key_sync;
    logic [DEB_W-1:0] deb_cnt;

    // Bring the asynchronous key pin into the sys_clk domain; idle level is high.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
        end
    end

    // Accept a new level only after it has differed for DEB_CYC consecutive cycles.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_db  <= 1'b1;
            deb_cnt <= '0;
        end else if (key_sync != key_db) begin
            if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                key_db  <= key_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

endmodule : key_debounce

// File: rtl/led_pattern_ctrl.sv
// Multi-LED pattern controller: two debounced keys select off/blink/run/alternate.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int unsigned NUM_LED = 4,
    parameter int unsigned CNT_MAX = 25_000_000,
    parameter int unsigned DEB_CYC = 1_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [1:0]         key,
    output logic [NUM_LED-1:0] led
);

    localparam int unsigned TICK_W = $clog2(CNT_MAX);
    localparam int unsigned POS_W  = (NUM_LED > 2) ? $clog2(NUM_LED) : 1;

    // Reject illegal parameter sets at elaboration.
    if (NUM_LED < 2 || CNT_MAX < 2 || DEB_CYC < 2) begin : g_param_err
        $error("led_pattern_ctrl: NUM_LED, CNT_MAX and DEB_CYC must all be >= 2");
    end

    logic [1:0]         key_db;
    mode_t              mode_next;
    mode_t              mode_q;
    logic               mode_chg;
    logic               tick;
    logic [TICK_W-1:0]  tick_cnt;
    logic               phase;
    logic [POS_W-1:0]   pos;
    logic [NUM_LED-1:0] led_d;

    // One synchroniser/debouncer per key bit.
    for (genvar i = 0; i < 2; i++) begin : g_key
        key_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_key_debounce (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .key_in  (key[i]),
            .key_db  (key_db[i])
        );
    end

    // Keys are active-low, so the pressed pattern is the mode number.
    assign mode_next = mode_t'(~key_db);
    assign mode_chg  = (mode_next != mode_q);
    assign tick      = (tick_cnt == TICK_W'(CNT_MAX - 1));

    // Mode register follows the debounced keys every cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q <= MODE_OFF;
        end else begin
            mode_q <= mode_next;
        end
    end

    // Blink timebase, phase and running-light position; a mode change restarts them all.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt <= '0;
            phase    <= 1'b0;
            pos      <= '0;
        end else if (mode_chg) begin
            tick_cnt <= '0;
            phase    <= 1'b0;
            pos      <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            phase    <= ~phase;
            if (mode_q == MODE_RUN) begin
                if (pos == POS_W'(NUM_LED - 1)) begin
                    pos <= '0;
                end else begin
                    pos <= pos + POS_W'(1);
                end
            end
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Pattern decode from the registered mode, phase and position.
    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_BLINK: led_d = {NUM_LED{~phase}};
            MODE_RUN:   led_d = NUM_LED'(1) << pos;
            MODE_ALT: begin
                for (int i = 0; i < int'(NUM_LED); i++) begin
                    led_d[i] = (i % 2 == 0) ? ~phase : phase;
                end
            end
            default:    led_d = '0;
        endcase
    end

    // Registered LED drive; dark on reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led <= '0;
        end else begin
            led <= led_d;
        end
    end

endmodule : led_pattern_ctrl

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl with short tick and debounce periods.
module tb_led_pattern_ctrl;
    import led_pattern_pkg::*;

    localparam int unsigned NUM_LED = 4;
    localparam int unsigned CNT_MAX = 5;
    localparam int unsigned DEB_CYC = 4;
    localparam int unsigned LAT     = DEB_CYC + 4;

    typedef struct {
        int unsigned        cyc;
        logic [NUM_LED-1:0] led;
    } sb_item_t;

    logic               sys_clk;
    logic               sys_rst;
    logic [1:0]         key;
    logic [NUM_LED-1:0] led;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;
    sb_item_t    sb_q[$];
    mode_t       cur_mode;
    int          cur_entry;

    led_pattern_ctrl #(
        .NUM_LED (NUM_LED),
        .CNT_MAX (CNT_MAX),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key     (key),
        .led     (led)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Edge counter: after posedge N, cyc == N.
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference pattern k cycles after the pattern first appears on led.
    function automatic logic [NUM_LED-1:0] model_led(input mode_t m, input int k);
        int step;
        logic [NUM_LED-1:0] v;
        step = k / int'(CNT_MAX);
        v = '0;
        case (m)
            MODE_BLINK: v = (step % 2 == 0) ? '1 : '0;
            MODE_RUN:   v[step % int'(NUM_LED)] = 1'b1;
            MODE_ALT: begin
                for (int i = 0; i < int'(NUM_LED); i++) begin
                    v[i] = ((i % 2 == 0) == (step % 2 == 0));
                end
            end
            default:    v = '0;
        endcase
        return v;
    endfunction

    // Queue expected led values for cycles start+1 .. start+hold around a mode change.
    task automatic expect_transition(input int start, input mode_t new_mode, input int hold);
        sb_item_t it;
        for (int c = start + 1; c <= start + hold; c++) begin
            it.cyc = c;
            if (c < start + int'(LAT)) it.led = model_led(cur_mode, c - cur_entry);
            else                       it.led = model_led(new_mode, c - (start + int'(LAT)));
            sb_q.push_back(it);
        end
        cur_mode  = new_mode;
        cur_entry = start + int'(LAT);
    endtask

    // Drive a new key level just after a negedge and hold it.
    task automatic change_key(input logic [1:0] k, input int hold);
        key = k;
        expect_transition(int'(cyc), mode_t'(~k), hold);
        repeat (hold) @(negedge sys_clk);
    endtask

    // Compare led against the scoreboard away from the active edge.
    always @(negedge sys_clk) begin
        sb_item_t e;
        if (!sys_rst) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                check_eq("sb_stale", cyc, e.cyc);
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                check_eq("led", 32'(led), 32'(e.led));
            end
        end
    end

    initial begin
        sys_rst   = 1'b1;
        key       = 2'b11;
        cur_mode  = MODE_OFF;
        cur_entry = 0;

        // Reset with keys idle, then 50 dark cycles.
        repeat (3) @(negedge sys_clk);
        check_eq("rst_led", 32'(led), 0);
        check_eq("rst_mode", 32'(dut.mode_q), 32'(MODE_OFF));
        sys_rst = 1'b0;
        expect_transition(int'(cyc), MODE_OFF, 50);
        repeat (50) @(negedge sys_clk);

        // BLINK, then back to OFF.
        change_key(2'b10, 20);
        change_key(2'b11, 12);

        // RUN with wrap, ALT, asymmetric release ALT->BLINK, then OFF.
        change_key(2'b01, 30);
        change_key(2'b00, 20);
        change_key(2'b10, 15);
        change_key(2'b11, 12);

        // Short bounce must be discarded.
        expect_transition(int'(cyc), MODE_OFF, 20);
        key = 2'b10;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (i == 2) key = 2'b11;
            check_eq("bounce_mode", 32'(dut.mode_q), 32'(MODE_OFF));
        end

        // Asynchronous reset during RUN at pos 2, recovery with key still held.
        change_key(2'b01, 19);
        check_eq("run_pos", 32'(dut.pos), 2);
        check_eq("run_led_pre", 32'(led), 32'h4);
        #2;
        sys_rst = 1'b1;
        #1;
        check_eq("async_rst_led", 32'(led), 0);
        repeat (2) begin
            @(negedge sys_clk);
            check_eq("rst_hold_led", 32'(led), 0);
        end
        sys_rst   = 1'b0;
        cur_mode  = MODE_OFF;
        cur_entry = 0;
        expect_transition(int'(cyc), MODE_RUN, 14);
        repeat (14) @(negedge sys_clk);

        // Drain with a bounded wait.
        for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge sys_clk);
        check_eq("sb_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_led_pattern_ctrl
